// File: rtl/vram_arbiter_pkg.sv
// Shared types and widths for the VRAM arbiter: selection modes, VRAM bus widths
// and the per-read return tag carried down the read pipeline.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 16;
  localparam int VRAM_BE_WIDTH   = 2;
  localparam int MAX_PORTS       = 8;
  // Wide enough to name any port up to MAX_PORTS, and to express out-of-range indices.
  localparam int EXCL_PORT_WIDTH = 3;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic                       vld;
    logic [EXCL_PORT_WIDTH-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_rr_priority_picker.sv
// Combinational winner selection: eligible vector + last-grant pointer + mode
// -> one-hot grant, encoded index and an any-grant flag.
module rr_priority_picker
  import vram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]       eligible_i,
  input  logic [EXCL_PORT_WIDTH-1:0] ptr_i,
  input  arb_mode_e                  mode_i,
  output logic [NUM_PORTS-1:0]       gnt_o,
  output logic [EXCL_PORT_WIDTH-1:0] idx_o,
  output logic                       any_o
);

  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    // Round-robin scans from the port after the pointer, wrapping back to the pointer last.
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (mode_i == ARB_RR) begin
        cand = int'(ptr_i) + 1 + k;
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      end else begin
        cand = k;
      end
      if (!any_o && eligible_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = EXCL_PORT_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// N-port VRAM arbiter: one grant per cycle, registered VRAM command one cycle later,
// read data returned in order to the issuing port READ_LATENCY+2 cycles after grant.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            rr_mode_i,
  input  logic                            excl_en_i,
  input  logic [EXCL_PORT_WIDTH-1:0]      excl_port_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            req_wr_i,
  input  logic [2*NUM_PORTS-1:0]          req_be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            vram_en_o,
  output logic                            vram_rd_o,
  output logic                            vram_wr_o,
  output logic [VRAM_BE_WIDTH-1:0]        vram_be_o,
  output logic [ADDR_WIDTH-1:0]           vram_addr_o,
  output logic [DATA_WIDTH-1:0]           vram_data_out_o,
  input  logic [DATA_WIDTH-1:0]           vram_data_in_i
);

  logic [NUM_PORTS-1:0]       excl_mask;
  logic [NUM_PORTS-1:0]       eligible;
  logic [NUM_PORTS-1:0]       gnt_raw;
  logic [EXCL_PORT_WIDTH-1:0] gnt_idx;
  logic                       gnt_any;

  logic                       sel_wr;
  logic [VRAM_BE_WIDTH-1:0]   sel_be;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [DATA_WIDTH-1:0]      sel_wdata;

  logic [EXCL_PORT_WIDTH-1:0] ptr_q, ptr_d;
  logic                       en_q, en_d, rd_q, rd_d, wr_q, wr_d;
  logic [VRAM_BE_WIDTH-1:0]   be_q, be_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      dout_q, dout_d;
  rd_tag_t [READ_LATENCY:0]   tag_q, tag_d;
  logic [NUM_PORTS-1:0]       rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;

  // An out-of-range exclusive index matches no port, so nothing becomes eligible.
  always_comb begin
    excl_mask = '1;
    if (excl_en_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        excl_mask[p] = (excl_port_i == EXCL_PORT_WIDTH'(p));
      end
    end
  end

  assign eligible = req_i & excl_mask & {NUM_PORTS{~reset_i}};

  rr_priority_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .mode_i    (arb_mode_e'(rr_mode_i)),
    .gnt_o     (gnt_raw),
    .idx_o     (gnt_idx),
    .any_o     (gnt_any)
  );

  assign gnt_o = gnt_raw;

  always_comb begin
    sel_wr    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_raw[p]) begin
        sel_wr    = req_wr_i[p];
        sel_be    = req_be_i[p*VRAM_BE_WIDTH +: VRAM_BE_WIDTH];
        sel_addr  = req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d  = gnt_any ? gnt_idx : ptr_q;
    en_d   = gnt_any;
    rd_d   = gnt_any & ~sel_wr;
    wr_d   = gnt_any & sel_wr;
    be_d   = sel_be;
    addr_d = gnt_any ? sel_addr : addr_q;
    dout_d = (gnt_any && sel_wr) ? sel_wdata : '0;

    tag_d[0] = '{vld: rd_d, port: gnt_idx};
    for (int k = 1; k <= READ_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    // The last tag stage lines up with vram_data_in for that read.
    rvalid_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_d[p] = tag_q[READ_LATENCY].vld &&
                    (tag_q[READ_LATENCY].port == EXCL_PORT_WIDTH'(p));
    end
    rdata_d = tag_q[READ_LATENCY].vld ? vram_data_in_i : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q    <= EXCL_PORT_WIDTH'(NUM_PORTS - 1);
      en_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      tag_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      en_q     <= en_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      tag_q    <= tag_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign vram_en_o       = en_q;
  assign vram_rd_o       = rd_q;
  assign vram_wr_o       = wr_q;
  assign vram_be_o       = be_q;
  assign vram_addr_o     = addr_q;
  assign vram_data_out_o = dout_q;
  assign rvalid_o        = rvalid_q;
  assign rdata_o         = rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a cycle-indexed behavioural model.
module tb_vram_arbiter;

  localparam int N    = 3;
  localparam int RL   = 1;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          rr_mode, excl_en;
  logic [2:0]    excl_port;
  logic [N-1:0]  req, req_wr;
  logic [2*N-1:0] req_be;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata, vram_data_out, vin;
  logic          vram_en, vram_rd, vram_wr;
  logic [1:0]    vram_be;
  logic [AW-1:0] vram_addr;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk_i(clk), .reset_i(reset), .rr_mode_i(rr_mode), .excl_en_i(excl_en),
    .excl_port_i(excl_port), .req_i(req), .req_wr_i(req_wr), .req_be_i(req_be),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .vram_en_o(vram_en), .vram_rd_o(vram_rd), .vram_wr_o(vram_wr),
    .vram_be_o(vram_be), .vram_addr_o(vram_addr), .vram_data_out_o(vram_data_out),
    .vram_data_in_i(vin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic en, rd, wr;
    logic [1:0] be;
    logic [AW-1:0] addr, dout;
  } cmd_t;

  cmd_t          e_cmd  [MAXC];
  logic [N-1:0]  e_rv   [MAXC];
  int            e_src  [MAXC];
  logic [DW-1:0] vin_hist [MAXC];
  int            cyc = 0;
  bit            mvalid = 0;
  int            m_ptr = N - 1;
  logic [DW-1:0] m_rdata = '0;

  function automatic int pick(logic [N-1:0] rq, bit rr, bit xe, logic [2:0] xp, int ptr);
    for (int off = 1; off <= N; off++) begin
      int p;
      p = rr ? (ptr + off) % N : off - 1;
      if (rq[p] && (!xe || int'(xp) == p)) return p;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    cmd_t nc;
    vin_hist[cyc] = vin;
    if (mvalid) begin
      chk("vram_en",  32'(vram_en),       32'(e_cmd[cyc].en));
      chk("vram_rd",  32'(vram_rd),       32'(e_cmd[cyc].rd));
      chk("vram_wr",  32'(vram_wr),       32'(e_cmd[cyc].wr));
      chk("vram_be",  32'(vram_be),       32'(e_cmd[cyc].be));
      chk("vram_addr", 32'(vram_addr),    32'(e_cmd[cyc].addr));
      chk("vram_dout", 32'(vram_data_out), 32'(e_cmd[cyc].dout));
      if (e_rv[cyc] != '0) m_rdata = vin_hist[e_src[cyc]];
      chk("rvalid", 32'(rvalid), 32'(e_rv[cyc]));
      chk("rdata",  32'(rdata),  32'(m_rdata));
    end
    w = reset ? -1 : pick(req, rr_mode, excl_en, excl_port, m_ptr);
    if (mvalid || reset) chk("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
    if (reset) begin
      e_cmd[cyc+1] = '0;
      for (int k = 1; k <= RL + 2; k++) e_rv[cyc+k] = '0;
      m_ptr   = N - 1;
      m_rdata = '0;
      mvalid  = 1;
    end else if (mvalid) begin
      nc = '0;
      e_rv[cyc+RL+2] = '0;
      if (w >= 0) begin
        m_ptr   = w;
        nc.en   = 1'b1;
        nc.wr   = req_wr[w];
        nc.rd   = !req_wr[w];
        nc.be   = req_be[w*2 +: 2];
        nc.addr = req_addr[w*AW +: AW];
        nc.dout = req_wr[w] ? req_wdata[w*DW +: DW] : '0;
        if (!req_wr[w]) begin
          e_rv[cyc+RL+2]  = N'(1) << w;
          e_src[cyc+RL+2] = cyc + 1 + RL;
        end
      end else begin
        nc.addr = e_cmd[cyc].addr;
      end
      e_cmd[cyc+1] = nc;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    vin = DW'($urandom);
  endtask

  task automatic set_port(input int p, input bit wr, input logic [1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[p]          = wr;
    req_be[p*2 +: 2]   = be;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  logic [N-1:0] exp_seq [8];
  logic [N-1:0] lastg, lastreq;

  initial begin
    reset = 1; rr_mode = 0; excl_en = 0; excl_port = 0;
    req = 0; req_wr = 0; req_be = 0; req_addr = 0; req_wdata = 0; vin = 0;
    next_cycle(); next_cycle();
    reset = 0;
    @(negedge clk);
    chk("reset_en",     32'(vram_en),   32'd0);
    chk("reset_addr",   32'(vram_addr), 32'd0);
    chk("reset_rvalid", 32'(rvalid),    32'd0);
    chk("reset_rdata",  32'(rdata),     32'd0);

    // Fixed priority: port 0 always wins, its address appears one cycle later.
    next_cycle();
    set_port(0, 0, 2'b11, 16'h0100, 16'h0);
    set_port(1, 0, 2'b11, 16'h0200, 16'h0);
    set_port(2, 0, 2'b11, 16'h0300, 16'h0);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fixed_gnt", 32'(gnt), 32'b001);
      if (i > 0) chk("fixed_addr", 32'(vram_addr), 32'h0100);
      next_cycle();
    end

    // Round robin from a fresh reset.
    reset = 1; req = 0;
    next_cycle();
    reset = 0; rr_mode = 1; req = 3'b111;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    exp_seq[4] = 3'b100; exp_seq[5] = 3'b001; exp_seq[6] = 3'b100; exp_seq[7] = 3'b001;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req = 3'b101;
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(exp_seq[i]));
      next_cycle();
    end

    // Read latency on port 1.
    req = 3'b010; set_port(1, 0, 2'b11, 16'h1234, 16'h0);
    @(negedge clk); chk("lat_gnt", 32'(gnt), 32'b010);
    next_cycle(); req = 0;
    @(negedge clk); chk("lat_rd", 32'(vram_rd), 32'd1); chk("lat_addr", 32'(vram_addr), 32'h1234);
    next_cycle(); vin = 16'hBEEF;
    next_cycle();
    @(negedge clk); chk("lat_rvalid", 32'(rvalid), 32'b010); chk("lat_rdata", 32'(rdata), 32'hBEEF);

    // Write with zero byte enables is still issued.
    next_cycle();
    req = 3'b001; set_port(0, 1, 2'b00, 16'h0042, 16'hA5A5);
    @(negedge clk); chk("wr_gnt", 32'(gnt), 32'b001);
    next_cycle(); req = 0;
    @(negedge clk);
    chk("wr_strobe", 32'(vram_wr), 32'd1);
    chk("wr_be",     32'(vram_be), 32'd0);
    chk("wr_dout",   32'(vram_data_out), 32'hA5A5);
    next_cycle(); next_cycle();
    @(negedge clk); chk("wr_no_rvalid", 32'(rvalid), 32'd0);

    // Exclusive switch with a port-0 read already in flight.
    next_cycle();
    req = 3'b001; set_port(0, 0, 2'b11, 16'h0777, 16'h0);
    @(negedge clk); chk("excl_pre_gnt", 32'(gnt), 32'b001);
    next_cycle(); excl_en = 1; excl_port = 2; req = 3'b111;
    @(negedge clk); chk("excl_gnt", 32'(gnt), 32'b100);
    next_cycle();
    @(negedge clk); chk("excl_gnt2", 32'(gnt), 32'b100);
    next_cycle(); excl_port = 5;
    @(negedge clk);
    chk("excl_ret_p0", 32'(rvalid), 32'b001);
    chk("excl_oob_gnt", 32'(gnt), 32'd0);

    // Reset with two reads outstanding.
    next_cycle(); excl_en = 0; rr_mode = 1; req = 3'b011;
    set_port(0, 0, 2'b11, 16'h0010, 16'h0); set_port(1, 0, 2'b11, 16'h0011, 16'h0);
    @(negedge clk); chk("rst_gnt_a", 32'(gnt), 32'b001);
    next_cycle(); req = 3'b010;
    @(negedge clk); chk("rst_gnt_b", 32'(gnt), 32'b010);
    next_cycle(); reset = 1; req = 0;
    next_cycle(); reset = 0;
    @(negedge clk);
    chk("rst_vram_en",   32'(vram_en), 32'd0);
    chk("rst_vram_rd",   32'(vram_rd), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_rvalid_a",  32'(rvalid), 32'd0);
    next_cycle(); req = 3'b111;
    @(negedge clk);
    chk("rst_rvalid_b", 32'(rvalid), 32'd0);
    chk("rst_gnt_p0",   32'(gnt), 32'b001);
    next_cycle(); req = 0;

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      lastg = gnt; lastreq = req;
      next_cycle();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) rr_mode = 1'($urandom);
      if ($urandom_range(0, 19) == 0) excl_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)  excl_port = 3'($urandom_range(0, 7));
      for (int p = 0; p < N; p++) begin
        if (!(lastreq[p] && !lastg[p] && $urandom_range(0, 9) != 0)) begin
          req[p] = 1'($urandom_range(0, 1));
          set_port(p, 1'($urandom), 2'($urandom), AW'($urandom), DW'($urandom));
        end
      end
    end
    next_cycle(); reset = 0; req = 0;
    repeat (6) next_cycle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
